// File: rtl/gpio_pkg.sv
// Shared GPIO constants, so the data-memory decoder and the result port
// agree on the port address and the bus widths.
package gpio_pkg;

    localparam int unsigned GPIO_DATA_W    = 32;
    localparam int unsigned GPIO_ADDR_W    = 32;
    localparam logic [31:0] GPIO_BASE_ADDR = 32'h0000_ABCD;
    localparam int unsigned GPIO_HITS      = 2;

endpackage

// File: rtl/edge_counter.sv
// Counts distinct runs of a match signal and pulses fire_c on the edge that
// detects every HITS-th run.
module edge_counter
    import gpio_pkg::*;
#(
    parameter int unsigned HITS = GPIO_HITS
) (
    input  logic clk,
    input  logic rst,
    input  logic match,
    output logic fire_c
);

    localparam int unsigned CNT_W = $clog2(HITS + 1);

    logic             match_q;
    logic [CNT_W-1:0] count;
    logic             hit_c;
    logic             last_c;

    // A hit is the first sampled cycle of a matching run.
    assign hit_c  = match & ~match_q;
    assign last_c = (count == CNT_W'(HITS - 1));
    assign fire_c = hit_c & last_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
            count   <= '0;
        end else begin
            match_q <= match;
            if (hit_c) begin
                count <= last_c ? '0 : count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_result_port.sv
// Memory-mapped result port: latches the write-data bus into salida on every
// HITS-th distinct access to GPIO_ADDR.
module gpio_result_port
    import gpio_pkg::*;
#(
    parameter int unsigned          DATA_W    = GPIO_DATA_W,
    parameter int unsigned          ADDR_W    = GPIO_ADDR_W,
    parameter logic [ADDR_W-1:0]    GPIO_ADDR = ADDR_W'(GPIO_BASE_ADDR),
    parameter int unsigned          HITS      = GPIO_HITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] direccion,
    input  logic [DATA_W-1:0] datos,
    output logic [DATA_W-1:0] salida
);

    logic match_c;
    logic fire_c;

    assign match_c = (direccion == GPIO_ADDR);

    edge_counter #(
        .HITS   (HITS)
    ) u_edge_counter (
        .clk    (clk),
        .rst    (rst),
        .match  (match_c),
        .fire_c (fire_c)
    );

    // datos only reaches salida on the detecting edge of the final access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            salida <= '0;
        end else if (fire_c) begin
            salida <= datos;
        end
    end

endmodule

// File: tb/tb_gpio_result_port.sv
// Directed bench for gpio_result_port with hand-computed expected outputs.
module tb_gpio_result_port;

    localparam logic [31:0] GPIO = 32'h0000_ABCD;
    localparam logic [31:0] IDLE = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] direccion;
    logic [31:0] datos;
    logic [31:0] salida;

    int checks = 0;
    int errors = 0;

    gpio_result_port dut (
        .clk       (clk),
        .rst       (rst),
        .direccion (direccion),
        .datos     (datos),
        .salida    (salida)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are then sampled there too.
    task automatic step(input logic [31:0] a, input logic [31:0] d);
        direccion = a;
        datos     = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        direccion = GPIO;
        datos     = 32'd4;

        // 1: reset holds everything at zero even while the address matches
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold", salida, 32'd0);
        end
        rst = 1'b0;
        step(IDLE, 32'd4);
        check("reset_release", salida, 32'd0);

        // 2: two accesses load datos on the edge starting the second run
        for (int i = 0; i < 4; i++) begin
            step(GPIO, 32'd4);
            check("first_run", salida, 32'd0);
        end
        step(IDLE, 32'd4);
        step(IDLE, 32'd4);
        check("gap", salida, 32'd0);
        step(GPIO, 32'd4);
        check("second_hit", salida, 32'd4);
        step(GPIO, 32'd5);
        check("same_run_ignored", salida, 32'd4);
        step(IDLE, 32'd6);
        check("hold_after", salida, 32'd4);

        // 4: third access leaves salida alone, fourth loads 0x1234
        step(GPIO, 32'h1234);
        check("third_hit", salida, 32'd4);
        step(IDLE, 32'h1234);
        step(GPIO, 32'h1234);
        check("fourth_hit", salida, 32'h1234);
        step(IDLE, 32'h1234);

        // 3: a long run with changing data is a single access
        for (int i = 0; i < 20; i++) begin
            step(GPIO, 32'hC000_0000 + 32'(i));
        end
        check("long_run", salida, 32'h1234);
        step(IDLE, 32'h0);
        step(GPIO, 32'h55);
        check("after_long_run", salida, 32'h55);
        step(IDLE, 32'h0);

        // 5: near-miss addresses never register as accesses
        for (int i = 0; i < 4; i++) begin
            step(32'h0000_ABCC, 32'hDEAD_0000 + 32'(i));
            step(32'h0001_ABCD, 32'hDEAD_0100 + 32'(i));
            step(32'h8000_ABCD, 32'hDEAD_0200 + 32'(i));
        end
        check("near_miss", salida, 32'h55);
        step(GPIO, 32'hAA);
        check("post_miss_first", salida, 32'h55);
        step(IDLE, 32'h0);
        step(GPIO, 32'hBB);
        check("post_miss_second", salida, 32'hBB);
        step(IDLE, 32'h0);

        // 6: async reset between edges clears salida and the partial count
        step(GPIO, 32'h77);
        check("partial_count", salida, 32'hBB);
        step(IDLE, 32'h0);
        #2 rst = 1'b1;
        #1 check("async_clear", salida, 32'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        step(GPIO, 32'h99);
        check("post_reset_first", salida, 32'd0);
        step(IDLE, 32'h0);
        step(GPIO, 32'h99);
        check("post_reset_second", salida, 32'h99);

        // Reset released while matching: the first cycle counts as a hit
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        step(GPIO, 32'h11);
        check("release_match_first", salida, 32'd0);
        step(GPIO, 32'h12);
        step(IDLE, 32'h0);
        step(GPIO, 32'h22);
        check("release_match_second", salida, 32'h22);
        step(IDLE, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_result_port.md
Name: gpio_result_port

Overview:
- Memory-mapped output port. It watches the address bus for a fixed GPIO address and counts distinct accesses to it.
- On every second access it latches the data bus into a held 32-bit output, which exposes the final program result.
- Sits beside data memory in the processor datapath and shares its address and write-data buses.

Parameters:
- DATA_W, 32, width of data bus and output register.
- ADDR_W, 32, width of address bus.
- GPIO_ADDR, 32'h0000_ABCD, address that constitutes a GPIO access.
- HITS, 2, number of distinct accesses needed per output update (≥1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- direccion  input  ADDR_W  address bus.
- datos  input  DATA_W  write-data bus.
- salida  output  DATA_W  registered GPIO output value.

Behaviour:
- Reset (rst=1, async): salida=0, hit counter=0, match_q=0. All are held while rst=1. Release is synchronous-safe: the first update happens at the first posedge with rst=0.
- match = (direccion == GPIO_ADDR), full-width compare, combinational.
- match_q: register, match_q <= match each posedge.
- hit = match & ~match_q. This is the rising edge of match.
  - One access = one contiguous run of matching cycles, however long.
  - A new access requires at least one sampled non-matching cycle in between.
- Hit counter: width clog2(HITS+1).
  - On a posedge with hit, when count < HITS-1: count <= count+1.
  - On a posedge with hit, when count == HITS-1: count <= 0 and salida <= datos, using datos sampled at that same edge.
- No hit: count and salida hold.
- Latency: salida shows the new value immediately after the posedge that detects the HITS-th access (0 cycles after the detecting edge).
- datos is ignored at all other times, including later cycles of the same matching run.
- Glitches between edges are ignored; only sampled values count.
- Reset mid-count discards the partial count.
  - If direccion == GPIO_ADDR at reset release, that first cycle counts as a hit, because match_q=0.
- Wrap: the update cycle repeats indefinitely, every HITS accesses.
- No X propagation from datos into salida except on update edges.

Decomposition:
- Shared package gpio_pkg holds GPIO_ADDR and the default DATA_W/ADDR_W constants, so the memory decoder and this block agree on the address.
- One sub-module is natural: edge_counter.
  - Contains the match_q register, rising-edge detect and modulo-HITS counter.
  - Outputs a single-cycle "fire" pulse.
  - Top level holds the compare and the salida register.

Test Plan:
1. Reset: rst=1 with direccion=0xABCD, datos=4 -> salida=0 throughout, counter 0. Deassert rst with direccion=0 -> salida stays 0.
2. Two accesses: datos=4, direccion=0xABCD for 4 cycles, 0 for 2 cycles, 0xABCD again -> salida=0 after the first run. salida=4 at the posedge starting the second run and holds afterward.
3. Long single run: direccion=0xABCD held for 20 cycles with datos changing -> salida stays 0, since only one access is counted.
4. Repeat: after test 2, set datos=0x1234.
   - Third access -> salida remains 4.
   - Fourth access -> salida=0x1234.
5. Near-miss addresses: 0xABCC, 0x0001_ABCD and 0xABCD-with-bit31-set toggled repeatedly -> no hits, salida unchanged.
6. Async reset mid-count: one access, then rst pulsed for less than one clock period between edges -> salida=0 immediately. Two further accesses are then required to load datos.
